// File: rtl/dac_drv18_chk.sv
// Drive-register stage for the 18-element unit-cell DAC array: holds mid-scale
// until the upstream pipeline is warm, then registers SV and checks popcount(SV) against the delayed code.
module dac_drv18_chk #(
  parameter int N      = 18,
  parameter int OFFSET = 9,
  parameter int VLAT   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       V,
  input  logic [N-1:0]     SV,
  input  logic             clr_err,
  output logic [N-1:0]     sv_p,
  output logic [N-1:0]     sv_n,
  output logic             valid,
  output logic             mism,
  output logic             range_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic             range_sticky,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [N-1:0]      MID     = {{(N-OFFSET){1'b0}}, {OFFSET{1'b1}}};
  localparam logic signed [5:0] VMIN    = 6'(-OFFSET);
  localparam logic signed [5:0] VMAX    = 6'(N - OFFSET);
  localparam logic [5:0]        OFF6    = 6'(OFFSET);
  localparam logic [2:0]        WARM_LD = 3'(VLAT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  state_t     state;
  logic [2:0] wcnt;
  logic [5:0] vd_q [VLAT];
  logic [5:0] vd;
  logic [5:0] pop;
  logic       r_c;
  logic       m_c;
  logic       go_run;

  assign vd        = vd_q[VLAT-1];
  assign sv_n      = ~sv_p;
  assign dbg_state = state;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + {5'b0, SV[i]};
    end
  end

  // Out-of-range codes have no meaningful ones count, so they never count as a mismatch.
  assign r_c = ($signed(vd) < VMIN) || ($signed(vd) > VMAX);
  assign m_c = !r_c && (pop != (vd + OFF6));

  // True on every edge whose result lands in RUN, including the WARM->RUN edge,
  // so data, valid and checker flags always share one cycle.
  assign go_run = en && ((state == RUN) || ((state == WARM) && (wcnt == 3'd1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wcnt         <= '0;
      sv_p         <= MID;
      valid        <= 1'b0;
      mism         <= 1'b0;
      range_err    <= 1'b0;
      err_cnt      <= '0;
      err_sticky   <= 1'b0;
      range_sticky <= 1'b0;
      for (int i = 0; i < VLAT; i++) vd_q[i] <= '0;
    end else begin
      vd_q[0] <= V;
      for (int i = 1; i < VLAT; i++) vd_q[i] <= vd_q[i-1];

      if (!en) begin
        state <= IDLE;
        wcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= WARM;
            wcnt  <= WARM_LD;
          end
          WARM: begin
            if (wcnt == 3'd1) begin
              state <= RUN;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt - 3'd1;
            end
          end
          RUN:     state <= RUN;
          default: state <= IDLE;
        endcase
      end

      sv_p      <= go_run ? SV : MID;
      valid     <= go_run;
      mism      <= go_run && m_c;
      range_err <= go_run && r_c;

      // Clear wins over a same-cycle error so software never loses a clear.
      if (clr_err) begin
        err_cnt      <= '0;
        err_sticky   <= 1'b0;
        range_sticky <= 1'b0;
      end else begin
        if (go_run && m_c) begin
          err_sticky <= 1'b1;
          if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        end
        if (go_run && r_c) range_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_drv18_chk.sv
// Directed bench for dac_drv18_chk: driver pushes hand-computed expectations,
// a monitor pops one per clock and compares all outputs.
module tb_dac_drv18_chk;

  localparam int W = 41;
  localparam logic [17:0] MID = 18'h001FF;

  logic        clk = 1'b0;
  logic        rst, en, clr_err;
  logic [5:0]  v;
  logic [17:0] sv;

  logic [17:0] sv_p, sv_n;
  logic        valid, mism, range_err, err_sticky, range_sticky;
  logic [15:0] err_cnt;
  logic [1:0]  dbg_state;

  logic [17:0] s_sv_p, s_sv_n;
  logic        s_valid, s_mism, s_range_err, s_err_sticky, s_range_sticky;
  logic [1:0]  s_err_cnt;
  logic [1:0]  s_dbg_state;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dac_drv18_chk #(.N(18), .OFFSET(9), .VLAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .V(v), .SV(sv), .clr_err(clr_err),
    .sv_p(sv_p), .sv_n(sv_n), .valid(valid), .mism(mism), .range_err(range_err),
    .err_cnt(err_cnt), .err_sticky(err_sticky), .range_sticky(range_sticky),
    .dbg_state(dbg_state)
  );

  // Narrow-counter copy on the same stimulus exercises saturation quickly.
  dac_drv18_chk #(.N(18), .OFFSET(9), .VLAT(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .V(v), .SV(sv), .clr_err(clr_err),
    .sv_p(s_sv_p), .sv_n(s_sv_n), .valid(s_valid), .mism(s_mism), .range_err(s_range_err),
    .err_cnt(s_err_cnt), .err_sticky(s_err_sticky), .range_sticky(s_range_sticky),
    .dbg_state(s_dbg_state)
  );

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, queue the outputs expected after the next rising edge.
  task automatic cyc(input logic r, input logic e, input logic c,
                     input logic [5:0] vv, input logic [17:0] s,
                     input logic [17:0] esvp, input logic ev, input logic em,
                     input logic er, input logic [15:0] ecnt, input logic ees,
                     input logic ers, input logic [1:0] esat);
    @(negedge clk);
    rst = r; en = e; clr_err = c; v = vv; sv = s;
    exp_q.push_back({esvp, ev, em, er, ecnt, ees, ers, esat});
  endtask

  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sv_p",         sv_p,                    e[40:23]);
        chk("sv_n",         sv_n,                    ~e[40:23]);
        chk("valid",        {17'b0, valid},          {17'b0, e[22]});
        chk("mism",         {17'b0, mism},           {17'b0, e[21]});
        chk("range_err",    {17'b0, range_err},      {17'b0, e[20]});
        chk("err_cnt",      {2'b0, err_cnt},         {2'b0, e[19:4]});
        chk("err_sticky",   {17'b0, err_sticky},     {17'b0, e[3]});
        chk("range_sticky", {17'b0, range_sticky},   {17'b0, e[2]});
        chk("sat_err_cnt",  {16'b0, s_err_cnt},      {16'b0, e[1:0]});
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; v = '0; sv = '0;
    //   rst en clr  v          sv         | sv_p      val m  r  cnt  es rs sat
    cyc(1, 0, 0, 6'd0,      18'h00000,  MID,       0, 0, 0, 16'd0, 0, 0, 2'd0);
    cyc(1, 0, 0, 6'd0,      18'h00000,  MID,       0, 0, 0, 16'd0, 0, 0, 2'd0);
    // Warm-up: valid rises on the second edge after en is sampled
    cyc(0, 1, 0, 6'd0,      18'h00000,  MID,       0, 0, 0, 16'd0, 0, 0, 2'd0);
    cyc(0, 1, 0, 6'd0,      18'h00000,  MID,       0, 0, 0, 16'd0, 0, 0, 2'd0);
    cyc(0, 1, 0, 6'd0,      MID,        MID,       1, 0, 0, 16'd0, 0, 0, 2'd0);
    // Clean RUN data at the code extremes
    cyc(0, 1, 0, 6'd9,      MID,        MID,       1, 0, 0, 16'd0, 0, 0, 2'd0);
    cyc(0, 1, 0, -6'sd9,    18'h3FFFF,  18'h3FFFF, 1, 0, 0, 16'd0, 0, 0, 2'd0);
    cyc(0, 1, 0, 6'd3,      18'h00000,  18'h00000, 1, 0, 0, 16'd0, 0, 0, 2'd0);
    // V=3 wants 12 ones; 11 ones is a mismatch, then clear on a second one
    cyc(0, 1, 0, 6'd3,      18'h007FF,  18'h007FF, 1, 1, 0, 16'd1, 1, 0, 2'd1);
    cyc(0, 1, 1, 6'd0,      18'h007FF,  18'h007FF, 1, 1, 0, 16'd0, 0, 0, 2'd0);
    // Out-of-range code -12: range flag only
    cyc(0, 1, 0, -6'sd12,   MID,        MID,       1, 0, 0, 16'd0, 0, 0, 2'd0);
    cyc(0, 1, 0, 6'd0,      18'h3FFFF,  18'h3FFFF, 1, 0, 1, 16'd0, 0, 1, 2'd0);
    // Four mismatches: 2-bit copy saturates at 3
    cyc(0, 1, 0, 6'd0,      18'h0000F,  18'h0000F, 1, 1, 0, 16'd1, 1, 1, 2'd1);
    cyc(0, 1, 0, 6'd0,      18'h0000F,  18'h0000F, 1, 1, 0, 16'd2, 1, 1, 2'd2);
    cyc(0, 1, 0, 6'd0,      18'h0000F,  18'h0000F, 1, 1, 0, 16'd3, 1, 1, 2'd3);
    cyc(0, 1, 0, 6'd0,      18'h0000F,  18'h0000F, 1, 1, 0, 16'd4, 1, 1, 2'd3);
    cyc(0, 1, 0, 6'd0,      MID,        MID,       1, 0, 0, 16'd4, 1, 1, 2'd3);
    // Drop en mid-RUN, re-enable; error state retained
    cyc(0, 0, 0, 6'd5,      18'h2A5A5,  MID,       0, 0, 0, 16'd4, 1, 1, 2'd3);
    cyc(0, 1, 0, 6'd0,      18'h15A5A,  MID,       0, 0, 0, 16'd4, 1, 1, 2'd3);
    cyc(0, 1, 0, 6'd0,      18'h00000,  MID,       0, 0, 0, 16'd4, 1, 1, 2'd3);
    cyc(0, 1, 0, 6'd0,      MID,        MID,       1, 0, 0, 16'd4, 1, 1, 2'd3);
    // Range boundaries: 9 in range, 10 and -10 out
    cyc(0, 1, 0, 6'd9,      MID,        MID,       1, 0, 0, 16'd4, 1, 1, 2'd3);
    cyc(0, 1, 0, 6'd10,     18'h3FFFF,  18'h3FFFF, 1, 0, 0, 16'd4, 1, 1, 2'd3);
    cyc(0, 1, 0, 6'd0,      18'h00000,  18'h00000, 1, 0, 1, 16'd4, 1, 1, 2'd3);
    cyc(0, 1, 0, -6'sd10,   MID,        MID,       1, 0, 0, 16'd4, 1, 1, 2'd3);
    cyc(0, 1, 0, 6'd0,      18'h00000,  18'h00000, 1, 0, 1, 16'd4, 1, 1, 2'd3);
    cyc(0, 1, 1, 6'd0,      MID,        MID,       1, 0, 0, 16'd0, 0, 0, 2'd0);
    cyc(0, 0, 0, 6'd0,      18'h3FFFF,  MID,       0, 0, 0, 16'd0, 0, 0, 2'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dac_drv18_chk.md
Name: dac_drv18_chk

Overview:
- Output stage directly downstream of the 18-element ISI/mismatch-shaping selection logic.
- Registers the 18-bit selection vector SV into complementary unit-cell drive vectors for the analog current-steering array.
- Forces a known mid-scale pattern during start-up and disable, until the upstream pipeline is valid.
- Checks every cycle that popcount(SV) equals the delayed input code V + OFFSET; flags, counts and latches violations for debug/BIST.

Parameters:
- N, 18, number of unit elements / SV width.
- OFFSET, 9, ones count for V=0 (valid V range -OFFSET..N-OFFSET).
- VLAT, 1, cycles from V at the upstream input to the matching SV (1..4).
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  block enable; 0 forces idle mid-scale output.
- V  in  6  signed input code, same cycle as upstream V.
- SV  in  N  selection vector from upstream, 1 = element on.
- clr_err  in  1  synchronous clear of err_cnt / err_sticky / range_sticky.
- sv_p  out  N  registered positive drive vector.
- sv_n  out  N  registered negative drive, always ~sv_p.
- valid  out  1  high in RUN state (checker active, drive = data).
- mism  out  1  registered popcount-mismatch flag.
- range_err  out  1  registered flag: delayed V outside valid range.
- err_cnt  out  CNT_W  saturating mismatch count.
- err_sticky  out  1  set on any mism, held until clr_err.
- range_sticky  out  1  set on any range_err, held until clr_err.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; sv_p=MID (low OFFSET bits 1, i.e. 18'h001FF); sv_n=~MID.
  - valid, mism, range_err, err_sticky, range_sticky = 0; err_cnt = 0.
  - V delay line cleared to 0.
- V delay line: VLAT-deep shift register on V, shifts every cycle regardless of en; Vd = oldest stage. Vd is aligned with SV.
- States:
  - IDLE: sv_p=MID, checker off. Goes to WARM when en=1.
  - WARM: counter loads VLAT+1 on entry and decrements; sv_p=MID, checker off. Goes to RUN when the counter reaches 0.
  - RUN: sv_p<=SV each cycle; valid=1.
  - Any state: en=0 → IDLE next edge; sv_p=MID from that edge on.
- Latency:
  - SV sampled at edge k appears on sv_p/sv_n after edge k, i.e. 1 cycle.
  - mism/range_err for that SV are valid in the same cycle as its sv_p.
- Checker, RUN only, combinational from SV and Vd, registered:
  - r = (Vd < -OFFSET) or (Vd > N-OFFSET), signed compare.
  - m = !r and (popcount(SV) != Vd+OFFSET), 6-bit unsigned compare.
  - mism<=m; range_err<=r. Both are forced to 0 outside RUN.
- err_cnt:
  - clr_err=1 → 0; this has priority, and a mismatch in the same cycle is dropped.
  - else m=1 and err_cnt != all-ones → +1.
  - Saturates at 2^CNT_W-1 with no wrap.
- err_sticky / range_sticky:
  - clr_err → 0.
  - else set by m / r; not counted in err_cnt when r.
  - Same priority rule as err_cnt.
- en toggled mid-RUN: WARM re-entered with full VLAT+1 count; error state retained, no implicit clear.
- sv_n is ~sv_p in every cycle, including reset.

Test Plan:
- Reset → sv_p=18'h001FF, sv_n=18'h3FE00, valid=0, err_cnt=0. Then en=1: valid rises exactly VLAT+1=2 cycles after the en edge; sv_p stays MID until then.
- RUN: V=0 then SV=18'h001FF; V=+9 then SV=18'h3FFFF; V=-9 then SV=0 (SV one cycle after V each time) → sv_p follows SV with 1-cycle latency; mism=0, err_cnt=0.
- RUN: V=3 with next-cycle SV having 11 ones → mism=1 for one cycle, err_cnt=1, err_sticky=1. Same cycle clr_err=1 on a second mismatch → err_cnt=0, err_sticky=0.
- V=-12 → range_err=1, range_sticky=1, mism=0, err_cnt unchanged.
- Force err_cnt to 16'hFFFE, inject 3 mismatches → err_cnt=16'hFFFF and holds.
- en=0 mid-RUN with random SV → next cycle sv_p=MID, valid=0, mism=0. en=1 → RUN after 2 cycles; prior err_cnt retained.
